fetch_control: RTL and testbench

FETCH_CONTROL -- requirements
Module: fetch_control

---
 rtl/fetch_control.sv | 100 ++++++++++
 tb/tb_fetch_control.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// Fetch/issue sequencer for a simple in-order core.
// Walks IDLE -> FETCH -> ISSUE, waits in ISSUE for execute to finish,
// then advances or redirects the instruction pointer, or stops in HALTED.
// Retired instructions are counted, including the one that halts.
// Every output comes straight from a flop, so no input reaches an output
// without passing through a clock edge.

module fetch_control #(
    parameter int                   WORD_SIZE    = 16,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [WORD_SIZE-1:0] pointer,
    output logic                 fetch_enable,
    output logic                 instr_valid,
    input  logic                 exec_done,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] branch_target,
    input  logic                 halt,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] retired_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state;

    // Sequencer: state, pointer, retired counter and the three status
    // outputs all update together so the flags always match the state.
    // NOTE: all state here is assigned with <= so every flop samples the
    // values from before the edge; mixing in = would create ordering races.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            pointer       <= RESET_VECTOR;
            retired_count <= '0;
            fetch_enable  <= 1'b0;
            instr_valid   <= 1'b0;
            halted        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state        <= FETCH;
                    fetch_enable <= 1'b1;
                    instr_valid  <= 1'b0;
                    halted       <= 1'b0;
                end

                FETCH: begin
                    state        <= ISSUE;
                    fetch_enable <= 1'b0;
                    instr_valid  <= 1'b1;
                    halted       <= 1'b0;
                end

                ISSUE: begin
                    // Without exec_done everything holds and the branch/halt
                    // inputs are not looked at.
                    if (exec_done) begin
                        retired_count <= retired_count + WORD_SIZE'(1);
                        instr_valid   <= 1'b0;
                        if (halt) begin
                            // Halt wins over a simultaneous branch; the
                            // pointer stays on the halting instruction.
                            state        <= HALTED;
                            fetch_enable <= 1'b0;
                            halted       <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            fetch_enable <= 1'b1;
                            pointer      <= branch_taken ? branch_target
                                                         : pointer + WORD_SIZE'(1);
                        end
                    end
                end

                HALTED: begin
                    // Parked until reset; inputs have no effect.
                    fetch_enable <= 1'b0;
                    instr_valid  <= 1'b0;
                    halted       <= 1'b1;
                end

                default: begin
                    state        <= IDLE;
                    fetch_enable <= 1'b0;
                    instr_valid  <= 1'b0;
                    halted       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control. A 16-bit instance carries the main
// scenarios; a 4-bit instance with a non-zero reset vector makes the
// retired counter wrap reachable in a short run.

module tb_fetch_control;

    logic        clk;
    logic        reset_n;
    logic        exec_done;
    logic        branch_taken;
    logic        halt;
    logic [15:0] branch_target;
    logic [15:0] pointer;
    logic [15:0] retired_count;
    logic        fetch_enable;
    logic        instr_valid;
    logic        halted;

    logic [3:0]  s_branch_target;
    logic [3:0]  s_pointer;
    logic [3:0]  s_retired_count;
    logic        s_fetch_enable;
    logic        s_instr_valid;
    logic        s_halted;

    int tests_run    = 0;
    int tests_failed = 0;

    // Observed bundle: {fetch_enable, instr_valid, halted, pointer, retired_count}
    logic [34:0] obs;
    logic [34:0] exp_v;
    logic [10:0] s_obs;
    logic [10:0] s_exp;

    assign obs   = {fetch_enable, instr_valid, halted, pointer, retired_count};
    assign s_obs = {s_fetch_enable, s_instr_valid, s_halted, s_pointer, s_retired_count};

    fetch_control #(.WORD_SIZE(16), .RESET_VECTOR(16'h0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pointer       (pointer),
        .fetch_enable  (fetch_enable),
        .instr_valid   (instr_valid),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .halted        (halted),
        .retired_count (retired_count)
    );

    fetch_control #(.WORD_SIZE(4), .RESET_VECTOR(4'hE)) dut_small (
        .clk           (clk),
        .reset_n       (reset_n),
        .pointer       (s_pointer),
        .fetch_enable  (s_fetch_enable),
        .instr_valid   (s_instr_valid),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (s_branch_target),
        .halt          (halt),
        .halted        (s_halted),
        .retired_count (s_retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges; leaves reset released with the FSM in IDLE.
    task automatic do_reset();
        reset_n         = 1'b0;
        exec_done       = 1'b0;
        branch_taken    = 1'b0;
        halt            = 1'b0;
        branch_target   = 16'h0000;
        s_branch_target = 4'h0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exec_done     = 1'b1;
        branch_taken  = 1'b1;
        halt          = 1'b1;
        branch_target = 16'h1234;
        reset_n       = 1'b0;
        tick();
        exp_v = {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        do_reset();
        exp_v = {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    // exec_done tied high: pointer and count step once per two cycles.
    task automatic test_sequence();
        do_reset();
        exec_done = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            tick();
            exp_v = {(i % 2 == 0), (i % 2 == 1), 1'b0, 16'(i / 2), 16'(i / 2)};
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL sequence[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    // Stall in ISSUE at pointer 5 with branch/halt noise, then branch to 0x40.
    task automatic test_stall_branch();
        do_reset();
        exec_done = 1'b1;
        tick();                       // FETCH @0
        tick();                       // ISSUE @0
        branch_taken  = 1'b1;
        branch_target = 16'h0005;
        tick();                       // FETCH @5, retired 1
        branch_taken = 1'b0;
        exec_done    = 1'b0;
        tick();                       // ISSUE @5
        branch_taken  = 1'b1;
        halt          = 1'b1;
        branch_target = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = {1'b0, 1'b1, 1'b0, 16'h0005, 16'h0001};
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        halt      = 1'b0;
        exec_done = 1'b1;
        tick();
        exp_v = {1'b1, 1'b0, 1'b0, 16'h0040, 16'h0002};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL branch_taken: got %h expected %h", obs, exp_v);
        end
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        tick();
        exp_v = {1'b0, 1'b1, 1'b0, 16'h0040, 16'h0002};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL branch_issue: got %h expected %h", obs, exp_v);
        end
    endtask

    // Execute-side inputs active during IDLE and FETCH must do nothing.
    task automatic test_idle_fetch_ignore();
        do_reset();
        exec_done     = 1'b1;
        branch_taken  = 1'b1;
        halt          = 1'b1;
        branch_target = 16'h0099;
        tick();
        exp_v = {1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL ignore_idle: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = {1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL ignore_fetch: got %h expected %h", obs, exp_v);
        end
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        halt         = 1'b0;
    endtask

    // Pointer 0xFFFF + 1 wraps to 0 and returns to FETCH.
    task automatic test_pointer_wrap();
        do_reset();
        exec_done = 1'b1;
        tick();
        tick();
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        tick();                       // FETCH @FFFF, retired 1
        branch_taken = 1'b0;
        tick();                       // ISSUE @FFFF
        exp_v = {1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0001};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL wrap_issue: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = {1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL pointer_wrap: got %h expected %h", obs, exp_v);
        end
        exec_done = 1'b0;
    endtask

    // 4-bit instance: reset vector 0xE, pointer and counter both wrap.
    task automatic test_counter_wrap();
        do_reset();
        s_exp = {1'b0, 1'b0, 1'b0, 4'hE, 4'h0};
        tests_run++;
        if (s_obs !== s_exp) begin
            tests_failed++;
            $display("FAIL small_reset_vector: got %h expected %h", s_obs, s_exp);
        end
        exec_done = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        // FETCH with 2 retired: pointer 0xE+2 wraps to 0x0
        s_exp = {1'b1, 1'b0, 1'b0, 4'h0, 4'h2};
        tests_run++;
        if (s_obs !== s_exp) begin
            tests_failed++;
            $display("FAIL small_pointer_wrap: got %h expected %h", s_obs, s_exp);
        end
        for (int i = 0; i < 26; i++) tick();
        s_exp = {1'b1, 1'b0, 1'b0, 4'hD, 4'hF};
        tests_run++;
        if (s_obs !== s_exp) begin
            tests_failed++;
            $display("FAIL small_count_max: got %h expected %h", s_obs, s_exp);
        end
        tick();
        tick();
        s_exp = {1'b1, 1'b0, 1'b0, 4'hE, 4'h0};
        tests_run++;
        if (s_obs !== s_exp) begin
            tests_failed++;
            $display("FAIL small_count_wrap: got %h expected %h", s_obs, s_exp);
        end
        exec_done = 1'b0;
    endtask

    // Halt beats branch at pointer 7; HALTED then ignores everything.
    task automatic test_halt();
        do_reset();
        exec_done = 1'b1;
        tick();
        tick();
        branch_taken  = 1'b1;
        branch_target = 16'h0007;
        tick();                       // FETCH @7, retired 1
        branch_taken = 1'b0;
        tick();                       // ISSUE @7
        halt          = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'h0020;
        tick();
        exp_v = {1'b0, 1'b0, 1'b1, 16'h0007, 16'h0002};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL halt_enter: got %h expected %h", obs, exp_v);
        end
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exec_done = (i % 2 == 0);
            tick();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL halt_hold[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    // Reset while HALTED, then reset mid-ISSUE with exec_done high.
    task automatic test_reset_priority();
        exec_done    = 1'b1;
        halt         = 1'b1;
        branch_taken = 1'b1;
        reset_n      = 1'b0;
        tick();
        exp_v = {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_from_halted: got %h expected %h", obs, exp_v);
        end
        reset_n      = 1'b1;
        halt         = 1'b0;
        branch_taken = 1'b0;
        tick();
        exp_v = {1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL restart_fetch: got %h expected %h", obs, exp_v);
        end
        tick();                       // ISSUE @0
        tick();                       // FETCH @1, retired 1
        tick();                       // ISSUE @1
        exp_v = {1'b0, 1'b1, 1'b0, 16'h0001, 16'h0001};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL pre_reset_issue: got %h expected %h", obs, exp_v);
        end
        halt    = 1'b1;
        reset_n = 1'b0;
        tick();
        exp_v = {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_in_issue: got %h expected %h", obs, exp_v);
        end
        reset_n   = 1'b1;
        halt      = 1'b0;
        exec_done = 1'b0;
        tick();
        exp_v = {1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL restart_after_issue: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        exec_done       = 1'b0;
        branch_taken    = 1'b0;
        halt            = 1'b0;
        branch_target   = 16'h0000;
        s_branch_target = 4'h0;
        test_reset();
        test_sequence();
        test_stall_branch();
        test_idle_fetch_ignore();
        test_pointer_wrap();
        test_counter_wrap();
        test_halt();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
